// File: rtl/lcd_init_sequencer.sv
// Power-on init sequencer for an HD44780-style LCD in 4-bit mode, paced by timer_15ms ticks.
// Optional debug output StepOut is enabled by defining LCD_STEP_OUT_EN.
module lcd_init_sequencer #(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned E_HIGH_CYCLES = 12,
    parameter int unsigned HOLD_CYCLES   = 2
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       start,
    input  logic       TimerIndicator,
    output logic       EnableCount,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [3:0] LCD_DATA,
    output logic       Busy,
    output logic       InitDone
`ifdef LCD_STEP_OUT_EN
    ,
    output logic [3:0] StepOut
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StSetup,
        StEHigh,
        StHold,
        StDone
    } state_e;

    localparam logic [7:0] SetupLast = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] EHighLast = 8'(E_HIGH_CYCLES - 1);
    localparam logic [7:0] HoldLast  = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0] LastStep  = 4'd13;

    state_e     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [3:0] data_q, data_d;
    logic [7:0] phase_q, phase_d;

    // Wake x3, 4-bit mode, then 0x28, 0x08, 0x01, 0x06, 0x0C as high/low nibble pairs.
    function automatic logic [3:0] rom_nibble(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd2: return 4'h3;
            4'd3, 4'd4:       return 4'h2;
            4'd5, 4'd7:       return 4'h8;
            4'd9:             return 4'h1;
            4'd11:            return 4'h6;
            4'd13:            return 4'hC;
            default:          return 4'h0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StWaitTick;
            end
            StWaitTick: begin
                if (TimerIndicator) begin
                    if (step_q <= LastStep) begin
                        state_d = StSetup;
                        data_d  = rom_nibble(step_q);
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StSetup: begin
                if (phase_q == SetupLast) state_d = StEHigh;
            end
            StEHigh: begin
                if (phase_q == EHighLast) state_d = StHold;
            end
            StHold: begin
                if (phase_q == HoldLast) begin
                    state_d = StWaitTick;
                    step_d  = step_q + 4'd1;
                end
            end
            StDone: begin
            end
            default: state_d = StIdle;
        endcase

        // Reload on every state change; saturate in the untimed states instead of wrapping.
        if (state_d != state_q) begin
            phase_d = '0;
        end else if (phase_q != 8'hFF) begin
            phase_d = phase_q + 8'd1;
        end else begin
            phase_d = phase_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q <= StIdle;
            step_q  <= '0;
            data_q  <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            data_q  <= data_d;
            phase_q <= phase_d;
        end
    end

    assign EnableCount = (state_q != StIdle);
    assign Busy        = (state_q == StWaitTick) || (state_q == StSetup) ||
                         (state_q == StEHigh) || (state_q == StHold);
    assign InitDone    = (state_q == StDone);
    assign LCD_E       = (state_q == StEHigh);
    assign LCD_DATA    = data_q;
    assign LCD_RS      = 1'b0;
    assign LCD_RW      = 1'b0;

`ifdef LCD_STEP_OUT_EN
    assign StepOut = step_q;
`endif

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Randomized self-checking bench for lcd_init_sequencer: strobes are captured by a monitor and
// compared against the expected nibble list and tick schedule.
module tb_lcd_init_sequencer;

    localparam int S      = 2;
    localparam int EH     = 12;
    localparam int H      = 2;
    localparam int PERIOD = 60;

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       TimerIndicator = 1'b0;
    logic       EnableCount, LCD_RS, LCD_RW, LCD_E, Busy, InitDone;
    logic [3:0] LCD_DATA;
`ifdef LCD_STEP_OUT_EN
    logic [3:0] step_out;
`endif

    lcd_init_sequencer #(
        .SETUP_CYCLES (S),
        .E_HIGH_CYCLES(EH),
        .HOLD_CYCLES  (H)
    ) dut (
        .clock         (clock),
        .rst           (rst),
        .start         (start),
        .TimerIndicator(TimerIndicator),
        .EnableCount   (EnableCount),
        .LCD_RS        (LCD_RS),
        .LCD_RW        (LCD_RW),
        .LCD_E         (LCD_E),
        .LCD_DATA      (LCD_DATA),
        .Busy          (Busy),
        .InitDone      (InitDone)
`ifdef LCD_STEP_OUT_EN
        ,
        .StepOut       (step_out)
`endif
    );

    always #5 clock = ~clock;

    logic [3:0] exp_nib [14] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0,
                                 4'h8, 4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'hC};

    int n_checks = 0;
    int n_errors = 0;

    // Tick source: periodic ticks are counted, injected ticks are not.
    int ticks_sent = 0;
    int tick_phase = 0;
    int tick_base = 0;
    bit inject_req = 1'b0;

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (tick_phase == PERIOD - 1) begin
                tick_phase = 0;
                TimerIndicator = 1'b1;
                ticks_sent++;
            end else begin
                tick_phase++;
                TimerIndicator = inject_req;
            end
            inject_req = 1'b0;
        end
    end

    // Strobe monitor.
    int         p_len[$];
    int         p_tick[$];
    logic [3:0] p_data[$];
    bit         p_stable[$];
    logic       prev_e = 1'b0;
    logic [3:0] prev_data = 4'h0;
    int         run = 0;
    int         high_len = 0;
    int         rise_tick = 0;
    int         hold_pend = 0;
    int         rsrw_bad = 0;
    int         done_tick = -1;

    initial begin
        forever begin
            @(negedge clock);
            if (LCD_DATA == prev_data) run++;
            else run = 1;
            prev_data = LCD_DATA;
            if (LCD_RS || LCD_RW) rsrw_bad++;
            if (InitDone && done_tick < 0) done_tick = ticks_sent - tick_base;
            if (LCD_E) begin
                if (!prev_e) begin
                    high_len  = 0;
                    rise_tick = ticks_sent - tick_base;
                end
                high_len++;
            end
            if (hold_pend != 0) hold_pend++;
            if (!LCD_E && prev_e) begin
                p_data.push_back(LCD_DATA);
                p_len.push_back(high_len);
                p_tick.push_back(rise_tick);
                hold_pend = 1;
            end
            if (hold_pend == H) begin
                p_stable.push_back(run >= S + EH + H);
                hold_pend = 0;
            end
            prev_e = LCD_E;
        end
    end

    task automatic clear_monitor();
        p_len.delete();
        p_tick.delete();
        p_data.delete();
        p_stable.delete();
        hold_pend = 0;
        rsrw_bad  = 0;
        done_tick = -1;
    endtask

    task automatic begin_sequence();
        @(posedge clock);
        #2;
        while (!(tick_phase >= 5 && tick_phase < 40)) begin
            @(posedge clock);
            #2;
        end
        repeat ($urandom_range(0, 8)) begin
            @(posedge clock);
            #2;
        end
        clear_monitor();
        tick_base = ticks_sent;
        start = 1'b1;
        @(negedge clock);
        n_checks++;
        if (EnableCount !== 1'b0) begin
            n_errors++;
            $display("FAIL enable_before_edge: got %b expected 0", EnableCount);
        end
        @(negedge clock);
        n_checks++;
        if ({EnableCount, Busy} !== 2'b11) begin
            n_errors++;
            $display("FAIL enable_after_start: got %b expected 11", {EnableCount, Busy});
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            inject_req = ($urandom_range(0, 3) == 0);
            @(negedge clock);
            n_checks++;
            if ({EnableCount, LCD_RS, LCD_RW, LCD_E, LCD_DATA, Busy, InitDone} !== 10'b0) begin
                n_errors++;
                $display("FAIL reset_outputs: got %b expected 0",
                         {EnableCount, LCD_RS, LCD_RW, LCD_E, LCD_DATA, Busy, InitDone});
            end
        end
        @(posedge clock);
        #2;
        start = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_full_sequence(input bit do_inject);
        bit injected = 1'b0;
        begin_sequence();
        start = 1'b0;
        for (int c = 0; c < 16 * PERIOD + 100 && InitDone !== 1'b1; c++) begin
            @(negedge clock);
            if (do_inject && !injected && p_data.size() == 4 && LCD_E === 1'b1) begin
                inject_req = 1'b1;
                injected = 1'b1;
            end
        end
        repeat (4) @(negedge clock);
        n_checks++;
        if (InitDone !== 1'b1) begin
            n_errors++;
            $display("FAIL init_done_timeout: got %b expected 1", InitDone);
        end
        if (do_inject) begin
            n_checks++;
            if (!injected) begin
                n_errors++;
                $display("FAIL inject_point: got 0 expected 1 (step 4 strobe never seen)");
            end
        end
        n_checks++;
        if (p_data.size() != 14) begin
            n_errors++;
            $display("FAIL pulse_count: got %0d expected 14", p_data.size());
        end
        for (int i = 0; i < 14 && i < p_data.size(); i++) begin
            n_checks++;
            if (p_data[i] !== exp_nib[i]) begin
                n_errors++;
                $display("FAIL nibble[%0d]: got %h expected %h", i, p_data[i], exp_nib[i]);
            end
            n_checks++;
            if (p_len[i] != EH) begin
                n_errors++;
                $display("FAIL e_width[%0d]: got %0d expected %0d", i, p_len[i], EH);
            end
            n_checks++;
            if (p_tick[i] != i + 1) begin
                n_errors++;
                $display("FAIL tick_before[%0d]: got %0d expected %0d", i, p_tick[i], i + 1);
            end
            n_checks++;
            if (i < p_stable.size() && p_stable[i] !== 1'b1) begin
                n_errors++;
                $display("FAIL data_stable[%0d]: got 0 expected 1", i);
            end
        end
        n_checks++;
        if (done_tick != 15) begin
            n_errors++;
            $display("FAIL done_tick: got %0d expected 15", done_tick);
        end
        n_checks++;
        if (rsrw_bad != 0) begin
            n_errors++;
            $display("FAIL rs_rw_zero: got %0d bad samples expected 0", rsrw_bad);
        end
    endtask

    task automatic test_done_idle();
        clear_monitor();
        for (int c = 0; c < 500; c++) begin
            @(posedge clock);
            #2;
            start = 1'($urandom_range(0, 1));
            inject_req = ($urandom_range(0, 9) == 0);
            @(negedge clock);
            n_checks++;
            if ({InitDone, LCD_E, LCD_DATA, Busy, EnableCount} !== 8'b1_0_1100_0_1) begin
                n_errors++;
                $display("FAIL done_hold: got %b expected 10110001",
                         {InitDone, LCD_E, LCD_DATA, Busy, EnableCount});
            end
        end
        start = 1'b0;
        n_checks++;
        if (p_data.size() != 0) begin
            n_errors++;
            $display("FAIL done_no_pulses: got %0d expected 0", p_data.size());
        end
    endtask

    task automatic test_reset_mid();
        bit reached = 1'b0;
        @(posedge clock);
        #2;
        rst = 1'b0;
        start = 1'b0;
        @(posedge clock);
        #2;
        rst = 1'b1;
        begin_sequence();
        for (int c = 0; c < 10 * PERIOD && !reached; c++) begin
            @(negedge clock);
            if (p_data.size() == 7 && LCD_E === 1'b1) reached = 1'b1;
        end
        n_checks++;
        if (!reached) begin
            n_errors++;
            $display("FAIL mid_reset_point: got 0 expected 1 (step 7 strobe never seen)");
        end
        @(posedge clock);
        #2;
        rst = 1'b0;
        start = 1'b0;
        @(posedge clock);
        #2;
        rst = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({EnableCount, LCD_RS, LCD_RW, LCD_E, LCD_DATA, Busy, InitDone} !== 10'b0) begin
            n_errors++;
            $display("FAIL mid_reset_outputs: got %b expected 0",
                     {EnableCount, LCD_RS, LCD_RW, LCD_E, LCD_DATA, Busy, InitDone});
        end
        repeat (100) @(negedge clock);
        n_checks++;
        if ({EnableCount, LCD_E, Busy} !== 3'b000) begin
            n_errors++;
            $display("FAIL idle_after_reset: got %b expected 000", {EnableCount, LCD_E, Busy});
        end
    endtask

    initial begin
        test_reset();
        test_full_sequence(1'b0);
        test_done_idle();
        test_reset_mid();
        test_full_sequence(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
